// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C temperature target: FSM states and the register map.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6
    } i2c_state_e;

    localparam logic [1:0] PTR_TEMP_MSB = 2'd0;
    localparam logic [1:0] PTR_TEMP_LSB = 2'd1;
    localparam logic [1:0] PTR_STATUS   = 2'd2;
    localparam logic [1:0] PTR_CONFIG   = 2'd3;

    localparam logic [7:0] STATUS_VALUE = 8'h80;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP detection; shared with the I2C master.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic clk_50MHz,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;

    // p0/p1: 2-FF synchronizer, p2: one-cycle history for edge detection
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= scl_in;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda_in;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign sda       = sda_p1;
    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    assign start_det =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
    assign stop_det  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;

endmodule

// File: rtl/i2c_temp_target.sv
// I2C target modelling the board temperature sensor: pointer-addressed register file,
// live temperature snapshotted per read, writable config register.
module i2c_temp_target #(
    parameter logic [6:0] I2C_ADDR = 7'h4B
) (
    input  logic        clk_50MHz,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_data,
    output logic [7:0]  config_reg,
    output logic        cfg_wr,
    output logic        busy
);

    import i2c_pkg::*;

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    function automatic logic [7:0] reg_byte(input logic [1:0]  ptr,
                                            input logic [15:0] temp,
                                            input logic [7:0]  cfg);
        logic [7:0] b;
        case (ptr)
            PTR_TEMP_MSB: b = temp[15:8];
            PTR_TEMP_LSB: b = temp[7:0];
            PTR_STATUS:   b = STATUS_VALUE;
            default:      b = cfg;
        endcase
        return b;
    endfunction

    i2c_state_e state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        first_wr_q, first_wr_d;
    logic        busy_d, sda_oe_d, cfg_wr_d;
    logic [7:0]  config_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  rd_byte;

    // The first byte of a read comes from the live word; later bytes from the snapshot.
    assign rd_byte = reg_byte(ptr_q, (state_q == ST_ADDR_ACK) ? temp_data : hold_q, config_reg);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ptr_d      = ptr_q;
        first_wr_d = first_wr_q;
        busy_d     = busy;
        sda_oe_d   = sda_oe;
        cfg_wr_d   = 1'b0;
        config_d   = config_reg;
        rx_d       = rx_q;
        tx_d       = tx_q;
        hold_d     = hold_q;

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;

                ST_ADDR: begin
                    if (scl_rise) begin
                        rx_d      = {rx_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (rx_q[7:1] == I2C_ADDR) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                            state_d  = ST_IDLE;
                        end
                    end
                end

                // rx_q[0] still holds the R/W bit of the address byte here
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rx_q[0]) begin
                            hold_d    = temp_data;
                            tx_d      = rd_byte;
                            sda_oe_d  = ~rd_byte[7];
                            bit_cnt_d = 4'd1;
                            state_d   = ST_RD_DATA;
                        end else begin
                            sda_oe_d   = 1'b0;
                            bit_cnt_d  = 4'd0;
                            first_wr_d = 1'b1;
                            state_d    = ST_WR_DATA;
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (scl_rise) begin
                        rx_d      = {rx_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (first_wr_q) begin
                            ptr_d      = rx_q[1:0];
                            first_wr_d = 1'b0;
                        end else begin
                            if (ptr_q == PTR_CONFIG) begin
                                config_d = rx_q;
                                cfg_wr_d = 1'b1;
                            end
                            ptr_d = ptr_q + 2'd1;
                        end
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WR_ACK;
                    end
                end

                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WR_DATA;
                    end
                end

                // bit_cnt counts bits already placed on the bus
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + 2'd1;
                            state_d  = ST_RD_ACK;
                        end else begin
                            sda_oe_d  = ~tx_q[6];
                            tx_d      = {tx_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                // Still here at a falling edge means the master ACKed on the rising edge.
                ST_RD_ACK: begin
                    if (scl_rise && sda) begin
                        sda_oe_d = 1'b0;
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end else if (scl_fall) begin
                        tx_d      = rd_byte;
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = 4'd1;
                        state_d   = ST_RD_DATA;
                    end
                end

                default: begin
                    sda_oe_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            ptr_q      <= PTR_TEMP_MSB;
            first_wr_q <= 1'b0;
            busy       <= 1'b0;
            sda_oe     <= 1'b0;
            cfg_wr     <= 1'b0;
            config_reg <= 8'h00;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ptr_q      <= ptr_d;
            first_wr_q <= first_wr_d;
            busy       <= busy_d;
            sda_oe     <= sda_oe_d;
            cfg_wr     <= cfg_wr_d;
            config_reg <= config_d;
        end
    end

    always_ff @(posedge clk_50MHz) begin
        rx_q   <= rx_d;
        tx_q   <= tx_d;
        hold_q <= hold_d;
    end

endmodule

// File: tb/tb_i2c_temp_target.sv
// Bench for i2c_temp_target: bit-banged I2C master against a register-map reference model.
module tb_i2c_temp_target;

    localparam logic [6:0] ADDR = 7'h4B;
    localparam int Q = 16;

    logic        clk_50MHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic [15:0] temp_data = 16'h0000;
    logic        sda_oe, cfg_wr, busy;
    logic [7:0]  config_reg;
    wire         sda_line = m_sda & ~sda_oe;

    int n_cmp = 0;
    int n_err = 0;
    int cfg_pulses = 0;
    int oe_cnt = 0;

    // reference model state
    int         mdl_ptr = 0;
    logic [7:0] mdl_cfg = 8'h00;
    logic [7:0] wq[$];

    always #10 clk_50MHz = ~clk_50MHz;

    i2c_temp_target #(.I2C_ADDR(ADDR)) dut (
        .clk_50MHz  (clk_50MHz),
        .rst_n      (rst_n),
        .scl_in     (m_scl),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .temp_data  (temp_data),
        .config_reg (config_reg),
        .cfg_wr     (cfg_wr),
        .busy       (busy)
    );

    always @(posedge clk_50MHz) if (cfg_wr) cfg_pulses <= cfg_pulses + 1;
    always @(negedge clk_50MHz) if (sda_oe) oe_cnt <= oe_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic clk_bit(input logic b, output logic r);
        m_sda = b;  tick(Q);
        m_scl = 1'b1; tick(Q);
        r = sda_line; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 0; i < 8; i++) clk_bit(b[7-i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, input bit mutate, input logic [15:0] nv,
                           output logic [7:0] b);
        logic r;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, r);
            b = {b[6:0], r};
            if (mutate && i == 3) temp_data = nv;
        end
        clk_bit(nack, r);
    endtask

    function automatic logic [7:0] mdl_reg(input int p, input logic [15:0] snap);
        case (p)
            0:       return snap[15:8];
            1:       return snap[7:0];
            2:       return 8'h80;
            default: return mdl_cfg;
        endcase
    endfunction

    task automatic xfer_write(input logic [7:0] data[$], input bit stop_after);
        logic ack;
        int p0, exp_p;
        p0 = cfg_pulses;
        exp_p = 0;
        i2c_start();
        wr_byte({ADDR, 1'b0}, ack);
        chk("wr_addr_ack", ack, 1'b0);
        chk("wr_busy", busy, 1'b1);
        foreach (data[i]) begin
            wr_byte(data[i], ack);
            chk("wr_data_ack", ack, 1'b0);
            if (i == 0) mdl_ptr = data[i] % 4;
            else begin
                if (mdl_ptr == 3) begin
                    mdl_cfg = data[i];
                    exp_p++;
                end
                mdl_ptr = (mdl_ptr + 1) % 4;
            end
        end
        if (stop_after) begin
            i2c_stop();
            chk("wr_busy_stop", busy, 1'b0);
        end
        chk("cfg_wr_pulses", cfg_pulses - p0, exp_p);
        chk("config_reg", config_reg, mdl_cfg);
    endtask

    task automatic xfer_read(input int n, input bit mutate, input logic [15:0] nv,
                             input bit stop_after);
        logic ack;
        logic [7:0]  b;
        logic [15:0] snap;
        i2c_start();
        snap = temp_data;
        wr_byte({ADDR, 1'b1}, ack);
        chk("rd_addr_ack", ack, 1'b0);
        chk("rd_busy", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            rd_byte(i == n - 1, mutate && i == 0, nv, b);
            chk($sformatf("rd_byte%0d_ptr%0d", i, mdl_ptr), b, mdl_reg(mdl_ptr, snap));
            mdl_ptr = (mdl_ptr + 1) % 4;
        end
        chk("rd_busy_nack", busy, 1'b0);
        chk("rd_oe_nack", sda_oe, 1'b0);
        if (stop_after) begin
            i2c_stop();
            chk("rd_oe_stop", sda_oe, 1'b0);
        end
    endtask

    task automatic xfer_bad(input logic [6:0] a);
        logic ack;
        int o0;
        i2c_start();
        o0 = oe_cnt;
        wr_byte({a, 1'($urandom_range(0, 1))}, ack);
        chk("bad_ack", ack, 1'b1);
        chk("bad_oe_cycles", oe_cnt - o0, 0);
        chk("bad_busy", busy, 1'b0);
        i2c_stop();
    endtask

    initial begin
        logic       ack;
        logic [6:0] a;
        int         nb;

        tick(4);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_config", config_reg, 8'h00);
        chk("rst_cfg_wr", cfg_wr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick(8);

        // two-byte read from pointer 0, live word changes mid-MSB
        temp_data = 16'h0C80;
        xfer_read(2, 1'b1, 16'h0D00, 1'b1);

        xfer_bad(7'h48);

        // config write, then pointer to config and read it back after a repeated START
        wq = {8'h03, 8'h5A};
        xfer_write(wq, 1'b1);
        wq = {8'h03};
        xfer_write(wq, 1'b0);
        xfer_read(1, 1'b0, 16'h0000, 1'b1);

        // pointer wrap 2 -> 3 -> 0
        temp_data = 16'hA1B2;
        wq = {8'h02};
        xfer_write(wq, 1'b0);
        xfer_read(3, 1'b0, 16'h0000, 1'b1);

        // reset while the target is driving a 0 data bit
        wq = {8'h00};
        xfer_write(wq, 1'b1);
        temp_data = 16'h1234;
        i2c_start();
        wr_byte({ADDR, 1'b1}, ack);
        chk("mid_addr_ack", ack, 1'b0);
        chk("mid_oe_before", sda_oe, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_oe_async", sda_oe, 1'b0);
        chk("mid_config", config_reg, 8'h00);
        chk("mid_busy", busy, 1'b0);
        tick(2);
        rst_n = 1'b1;
        mdl_ptr = 0;
        mdl_cfg = 8'h00;
        i2c_stop();
        tick(4);
        temp_data = 16'h6E3F;
        xfer_read(2, 1'b0, 16'h0000, 1'b1);

        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    wq = {8'($urandom_range(0, 255))};
                    xfer_write(wq, 1'($urandom_range(0, 1)));
                end
                1: begin
                    wq.delete();
                    wq.push_back({6'($urandom_range(0, 63)), 2'($urandom_range(2, 3))});
                    nb = $urandom_range(1, 2);
                    for (int k = 0; k < nb; k++) wq.push_back(8'($urandom_range(0, 255)));
                    xfer_write(wq, 1'($urandom_range(0, 1)));
                end
                2: begin
                    temp_data = 16'($urandom);
                    xfer_read($urandom_range(1, 4), 1'b1, 16'($urandom),
                              1'($urandom_range(0, 1)));
                end
                default: begin
                    do a = 7'($urandom_range(0, 127)); while (a == ADDR);
                    xfer_bad(a);
                end
            endcase
        end

        i2c_stop();
        chk("end_busy", busy, 1'b0);
        chk("end_config", config_reg, mdl_cfg);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
